bobc_sequencer: RTL and testbench

// - Shares the BOBC polynomial datapath between NREQ requesters and sequences it per operation.
// - Round-robin picks one requester, then steps the fixed 8-step control program (lx/m0/m1/m2/h/ls/lh).
// - Stalls at compute steps until the datapath asserts pronto, then pulses done to the winner.
// - Sits between client request logic and the datapath; the datapath operand mux is steered by sel.

---
 rtl/bobc_pkg.sv | 40 ++++
 rtl/bobc_rr_arbiter.sv | 39 +++
 rtl/bobc_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_bobc_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bobc_pkg.sv
// Shared definitions for the BOBC datapath sequencer.
// - ctrl_word_t : one row of the control program (datapath control word plus wait flag)
// - NSTEPS/PROG : the fixed 8-step control program, indexed by the step counter
// - state_t     : sequencer FSM state encoding
package bobc_pkg;

    // One program row; wt marks a compute step that waits for the datapath.
    typedef struct packed {
        logic       lx;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
        logic       ls;
        logic       lh;
        logic       wt;
    } ctrl_word_t;

    localparam int NSTEPS = 8;

    // Fields packed as lx_m0_m1_m2_h_ls_lh_wt.
    localparam ctrl_word_t PROG [0:NSTEPS-1] = '{
        11'b1_01_00_00_1_0_0_0,
        11'b0_01_00_00_1_0_1_0,
        11'b0_10_00_11_0_0_0_1,
        11'b0_10_00_11_0_0_1_0,
        11'b0_00_01_11_1_0_0_1,
        11'b0_00_01_11_1_0_1_0,
        11'b0_11_00_11_0_0_0_1,
        11'b0_11_00_11_0_1_0_0
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

endpackage

// File: rtl/bobc_rr_arbiter.sv
// Combinational round-robin picker.
// Scans last+1, last+2, ... (mod NREQ) and returns the first requester found.
// Ports:
//   req   in  NREQ  request vector
//   last  in  SELW  index of the most recently served client
//   grant out NREQ  one-hot winner (all zero when req is zero)
//   idx   out SELW  index of the winner (zero when req is zero)
module bobc_rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int SELW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] last,
    output logic [NREQ-1:0] grant,
    output logic [SELW-1:0] idx
);

    logic            found_s;
    logic [SELW-1:0] cand_s;

    // Rotating priority scan starting just after the last served client.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_s = SELW'((int'(last) + i) % NREQ);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                grant   = NREQ'(1) << cand_s;
                idx     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/bobc_sequencer.sv
// Shares the BOBC polynomial datapath between NREQ requesters.
// A round-robin winner is picked in IDLE, then the fixed control program is
// stepped; wait steps stall until pronto, guarded by an optional watchdog.
// All outputs are decoded from registered state only.
// Ports:
//   ck      in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   req     in   level request per client, held until its done
//   pronto  in   datapath result valid for the current compute step
//   gnt     out  one-hot grant, step 0 through the terminal cycle
//   sel     out  index of the granted client (steers the operand mux)
//   busy    out  high in every non-IDLE state
//   lx,m0,m1,m2,h,ls,lh out  datapath control word
//   done    out  one-cycle completion pulse to the granted client
//   err     out  one-cycle pulse with done when the watchdog aborted
module bobc_sequencer
    import bobc_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 16,
    localparam int SELW    = $clog2(NREQ)
) (
    input  logic            ck,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            pronto,
    output logic [NREQ-1:0] gnt,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            lx,
    output logic [1:0]      m0,
    output logic [1:0]      m1,
    output logic [1:0]      m2,
    output logic            h,
    output logic            ls,
    output logic            lh,
    output logic [NREQ-1:0] done,
    output logic            err
);

    localparam int              STW       = $clog2(NSTEPS);
    localparam int              WDW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0]  WDOG_LAST = WDW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [STW-1:0]  STEP_LAST = STW'(NSTEPS - 1);

    state_t          state_r, state_s;
    logic [STW-1:0]  step_r,  step_s;
    logic [WDW-1:0]  wdog_r,  wdog_s;
    logic [SELW-1:0] last_r,  last_s;
    logic [SELW-1:0] sel_r,   sel_s;

    logic [NREQ-1:0] arb_gnt_s;
    logic [SELW-1:0] arb_idx_s;
    logic [NREQ-1:0] onehot_s;
    ctrl_word_t      cw_s;

    bobc_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .last  (last_r),
        .grant (arb_gnt_s),
        .idx   (arb_idx_s)
    );

    assign cw_s     = PROG[step_r];
    assign onehot_s = NREQ'(1) << sel_r;

    // State register; last resets to NREQ-1 so client 0 has first priority.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            step_r  <= '0;
            wdog_r  <= '0;
            last_r  <= SELW'(NREQ - 1);
            sel_r   <= '0;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
            wdog_r  <= wdog_s;
            last_r  <= last_s;
            sel_r   <= sel_s;
        end
    end

    // Next-state logic: arbitration, step advance, wait handling and watchdog.
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        wdog_s  = wdog_r;
        last_s  = last_r;
        sel_s   = sel_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    sel_s   = arb_idx_s;
                    step_s  = '0;
                    wdog_s  = '0;
                    state_s = ST_STEP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                // pronto only matters on wait steps; it is ignored elsewhere.
                if (!cw_s.wt || pronto) begin
                    wdog_s = '0;
                    if (step_r == STEP_LAST) begin
                        state_s = ST_DONE;
                        step_s  = '0;
                    end else begin
                        step_s = step_r + STW'(1);
                    end
                end else if ((TIMEOUT > 0) && (wdog_r == WDOG_LAST)) begin
                    wdog_s  = '0;
                    step_s  = '0;
                    state_s = ST_ABORT;
                end else begin
                    wdog_s = wdog_r + WDW'(1);
                end
            end
            ST_DONE: begin
                last_s  = sel_r;
                state_s = ST_IDLE;
            end
            ST_ABORT: begin
                last_s  = sel_r;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                step_s  = '0;
                wdog_s  = '0;
            end
        endcase
    end

    // Output decode from registered state: control word only while stepping.
    always_comb begin
        gnt  = '0;
        sel  = sel_r;
        busy = 1'b0;
        lx   = 1'b0;
        m0   = 2'b00;
        m1   = 2'b00;
        m2   = 2'b00;
        h    = 1'b0;
        ls   = 1'b0;
        lh   = 1'b0;
        done = '0;
        err  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_STEP: begin
                gnt  = onehot_s;
                busy = 1'b1;
                lx   = cw_s.lx;
                m0   = cw_s.m0;
                m1   = cw_s.m1;
                m2   = cw_s.m2;
                h    = cw_s.h;
                ls   = cw_s.ls;
                lh   = cw_s.lh;
            end
            ST_DONE: begin
                gnt  = onehot_s;
                busy = 1'b1;
                done = onehot_s;
            end
            ST_ABORT: begin
                gnt  = onehot_s;
                busy = 1'b1;
                done = onehot_s;
                err  = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bobc_sequencer.sv
// Self-checking bench for bobc_sequencer (NREQ=4, TIMEOUT=16).
// Expected done events are queued when requests are driven and matched
// against the DUT's done/err pulses by a negedge monitor.
`timescale 1ns/1ps
module tb_bobc_sequencer;

    logic       ck;
    logic       rst;
    logic [3:0] req;
    logic       pronto;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       lx;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       ls;
    logic       lh;
    logic [3:0] done;
    logic       err;

    // Control word rows {lx,m0,m1,m2,h,ls,lh} of the program.
    localparam logic [9:0] PROG_T [8] = '{
        10'b1_01_00_00_1_0_0,
        10'b0_01_00_00_1_0_1,
        10'b0_10_00_11_0_0_0,
        10'b0_10_00_11_0_0_1,
        10'b0_00_01_11_1_0_0,
        10'b0_00_01_11_1_0_1,
        10'b0_11_00_11_0_0_0,
        10'b0_11_00_11_0_1_0
    };

    typedef struct {
        int client;
        bit err_exp;
        int edge_n;
    } sb_item_t;

    sb_item_t sb_q[$];
    sb_item_t sb_e;
    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int e0;
    int e1;

    bobc_sequencer #(.NREQ(4), .TIMEOUT(16)) dut (
        .ck     (ck),
        .rst    (rst),
        .req    (req),
        .pronto (pronto),
        .gnt    (gnt),
        .sel    (sel),
        .busy   (busy),
        .lx     (lx),
        .m0     (m0),
        .m1     (m1),
        .m2     (m2),
        .h      (h),
        .ls     (ls),
        .lh     (lh),
        .done   (done),
        .err    (err)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    always @(posedge ck) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] cw();
        return {lx, m0, m1, m2, h, ls, lh};
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (edge_cnt < target) tick();
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge ck);
            if (done !== 4'b0000) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_done", {28'd0, done}, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check_eq("done_client", {28'd0, done}, 32'd1 << sb_e.client);
                    check_eq("done_err", {31'd0, err}, {31'd0, sb_e.err_exp});
                    check_eq("done_cycle", edge_cnt, sb_e.edge_n);
                end
            end else if (err !== 1'b0) begin
                check_eq("stray_err", {31'd0, err}, 32'd0);
            end
        end
    end

    // Absolute time bound.
    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b0;
        req    = 4'b0000;
        pronto = 1'b1;
        tick();
        tick();
        check_eq("reset_outputs", {10'd0, gnt, sel, busy, lx, m0, m1, m2, h, ls, lh, done, err}, 32'd0);
        rst = 1'b1;
        tick();

        // Single client, pronto high: program rows 0..7, done at cycle 9.
        e0  = edge_cnt;
        req = 4'b0001;
        sb_q.push_back('{0, 1'b0, e0 + 9});
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("t1_word", {22'd0, cw()}, {22'd0, PROG_T[i]});
            check_eq("t1_gnt", {28'd0, gnt}, 32'd1);
        end
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        check_eq("t1_sel", {30'd0, sel}, 32'd0);
        tick();
        check_eq("t1_done_gnt", {28'd0, gnt}, 32'd1);
        check_eq("t1_done_word", {22'd0, cw()}, 32'd0);
        req = 4'b0000;
        tick();
        check_eq("t1_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("t1_idle_gnt", {28'd0, gnt}, 32'd0);

        // pronto low at step 1 (ignored) and for 3 cycles at step 2.
        e0  = edge_cnt;
        req = 4'b0001;
        sb_q.push_back('{0, 1'b0, e0 + 12});
        for (int j = 1; j <= 11; j++) begin
            tick();
            check_eq("t2_word", {22'd0, cw()},
                     {22'd0, PROG_T[(j <= 3) ? (j - 1) : ((j <= 6) ? 2 : (j - 4))]});
            if (j == 2) pronto = 1'b0;
            if (j == 6) pronto = 1'b1;
        end
        tick();
        req = 4'b0000;
        tick();

        // All four requesting from reset: order 0,1,2,3,0 with one IDLE gap.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        e0  = edge_cnt;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) sb_q.push_back('{k % 4, 1'b0, e0 + 9 + 10 * k});
        for (int k = 0; k < 5; k++) begin
            tick_to(e0 + 9 + 10 * k);
            check_eq("t3_gnt", {28'd0, gnt}, 32'd1 << (k % 4));
            if (k == 4) req = 4'b0000;
            tick();
            check_eq("t3_idle", {31'd0, busy}, 32'd0);
            if (k < 4) begin
                tick();
                check_eq("t3_next_busy", {31'd0, busy}, 32'd1);
                check_eq("t3_next_gnt", {28'd0, gnt}, 32'd1 << ((k + 1) % 4));
            end
        end

        // Watchdog: pronto stuck low, step 2 held 16 cycles then abort.
        pronto = 1'b0;
        e0     = edge_cnt;
        req    = 4'b0100;
        sb_q.push_back('{2, 1'b1, e0 + 19});
        tick_to(e0 + 3);
        for (int i = 0; i < 16; i++) begin
            check_eq("t4_hold", {22'd0, cw()}, {22'd0, PROG_T[2]});
            tick();
        end
        check_eq("t4_abort_word", {22'd0, cw()}, 32'd0);
        check_eq("t4_abort_err", {31'd0, err}, 32'd1);
        req = 4'b0000;
        tick();
        check_eq("t4_idle_busy", {31'd0, busy}, 32'd0);
        pronto = 1'b1;
        tick();

        // Reset asserted at step 5: outputs clear at once, no done.
        e0  = edge_cnt;
        req = 4'b0001;
        tick_to(e0 + 6);
        check_eq("t5_step5", {22'd0, cw()}, {22'd0, PROG_T[5]});
        rst = 1'b0;
        #1;
        check_eq("t5_async_clear", {10'd0, gnt, sel, busy, lx, m0, m1, m2, h, ls, lh, done, err}, 32'd0);
        tick();
        tick();
        req = 4'b0010;
        rst = 1'b1;
        e1  = edge_cnt;
        sb_q.push_back('{1, 1'b0, e1 + 9});
        tick();
        check_eq("t5_gnt1", {28'd0, gnt}, 32'd2);
        tick_to(e1 + 9);
        req = 4'b0000;
        tick();

        // req[0] dropped at step 3 with req[2] pending.
        e0  = edge_cnt;
        req = 4'b0001;
        sb_q.push_back('{0, 1'b0, e0 + 9});
        tick();
        check_eq("t6_gnt0", {28'd0, gnt}, 32'd1);
        req = 4'b0101;
        sb_q.push_back('{2, 1'b0, e0 + 19});
        tick_to(e0 + 4);
        req = 4'b0100;
        tick_to(e0 + 11);
        check_eq("t6_gnt2", {28'd0, gnt}, 32'd4);
        tick_to(e0 + 19);
        req = 4'b0000;
        tick();
        check_eq("t6_idle", {31'd0, busy}, 32'd0);

        tick();
        tick();
        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
